// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, selects the next PC, and latches the fetched instruction with its PC+4.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] idInstr_q, idInstr_d;
    logic [31:0] idPc4_q, idPc4_d;
    logic        idValid_q, idValid_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    logic [31:0] pc4;
    logic [31:0] jumpTarget;
    logic [31:0] branchAligned;
    logic        redirect;

    assign pc4           = pc_q + 32'd4;
    assign jumpTarget    = {idPc4_q[31:28], jump_index, 2'b00};
    assign branchAligned = branch_target & ~32'h0000_0003;
    assign redirect      = branch_taken | jump;

    // A redirect squashes the wrong-path fetch and overrides a stall on the PC.
    always_comb begin
        pc_d         = pc_q;
        idInstr_d    = idInstr_q;
        idPc4_d      = idPc4_q;
        idValid_d    = idValid_q;
        fetchCount_d = fetchCount_q;

        if (branch_taken) begin
            pc_d = branchAligned;
        end else if (jump) begin
            pc_d = jumpTarget;
        end else if (!stall) begin
            pc_d = pc4;
        end

        if (flush || redirect) begin
            idInstr_d = NOP_INSTR;
            idPc4_d   = 32'd0;
            idValid_d = 1'b0;
        end else if (!stall) begin
            idInstr_d    = imem_rdata;
            idPc4_d      = pc4;
            idValid_d    = 1'b1;
            fetchCount_d = fetchCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            idInstr_q    <= NOP_INSTR;
            idPc4_q      <= 32'd0;
            idValid_q    <= 1'b0;
            fetchCount_q <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            idInstr_q    <= idInstr_d;
            idPc4_q      <= idPc4_d;
            idValid_q    <= idValid_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_instr    = idInstr_q;
    assign id_pc4      = idPc4_q;
    assign id_valid    = idValid_q;
    assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: each driven cycle pushes the expected
// IF/ID and PC state, which is popped and compared one cycle later.
module tb_fetch_ifid_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] count;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int   nChecks;
    int   nFailures;
    obs_t sbQ[$];
    obs_t mdl;
    obs_t expv;
    obs_t act;

    fetch_ifid_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .id_instr     (id_instr),
        .id_pc4       (id_pc4),
        .id_valid     (id_valid),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word i holds i + 0x100.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr >> 2) + 32'h100;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    function automatic obs_t sampleDut();
        return obs_t'({id_instr, id_pc4, id_valid, imem_addr, fetch_count});
    endfunction

    // Drives one cycle, pushes the expected post-edge state, and steps the clock.
    task automatic applyStimulus(input logic st, input logic fl, input logic br,
                                 input logic [31:0] bt, input logic jp,
                                 input logic [25:0] ji);
        obs_t nxt;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_index    = ji;
        nxt = mdl;
        if (br)       nxt.pc = {bt[31:2], 2'b00};
        else if (jp)  nxt.pc = {mdl.pc4[31:28], ji, 2'b00};
        else if (!st) nxt.pc = mdl.pc + 32'd4;
        if (fl || br || jp) begin
            nxt.instr = 32'h0;
            nxt.pc4   = 32'h0;
            nxt.valid = 1'b0;
        end else if (!st) begin
            nxt.instr = memWord(mdl.pc);
            nxt.pc4   = mdl.pc + 32'd4;
            nxt.valid = 1'b1;
            nxt.count = mdl.count + 32'd1;
        end
        sbQ.push_back(nxt);
        mdl = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_index = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mdl = '0;
        sbQ.delete();
    endtask

    task automatic test_reset();
        doReset();
        act = sampleDut();
        nChecks++;
        if (act !== obs_t'(0)) begin
            nFailures++;
            $display("[TB] FAIL reset_state: got %h expected %h", act, obs_t'(0));
        end
    endtask

    task automatic test_free_run();
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            expv = sbQ.pop_front();
            act  = sampleDut();
            nChecks++;
            if (act !== expv) begin
                nFailures++;
                $display("[TB] FAIL free_run[%0d]: got %h expected %h", i, act, expv);
            end
        end
        nChecks++;
        if (fetch_count !== 32'd5 || id_instr !== 32'h104 || id_pc4 !== 32'h14 || id_valid !== 1'b1) begin
            nFailures++;
            $display("[TB] FAIL free_run_end: got count=%h instr=%h pc4=%h valid=%b expected 5/104/14/1",
                     fetch_count, id_instr, id_pc4, id_valid);
        end
    endtask

    task automatic test_stall();
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            void'(sbQ.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            expv = sbQ.pop_front();
            act  = sampleDut();
            nChecks++;
            if (act !== expv || imem_addr !== 32'h10 || fetch_count !== 32'd4) begin
                nFailures++;
                $display("[TB] FAIL stall_hold[%0d]: got %h expected %h (pc 10, count 4)", i, act, expv);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || id_instr !== 32'h104) begin
            nFailures++;
            $display("[TB] FAIL stall_release: got %h expected %h", act, expv);
        end
    endtask

    task automatic test_branch();
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(0, 0, 1, 32'h40, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || imem_addr !== 32'h40 || id_valid !== 1'b0) begin
            nFailures++;
            $display("[TB] FAIL branch_redirect: got %h expected %h", act, expv);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || id_instr !== 32'h110 || id_pc4 !== 32'h44) begin
            nFailures++;
            $display("[TB] FAIL branch_target_fetch: got %h expected %h", act, expv);
        end
        applyStimulus(0, 0, 1, 32'h43, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || imem_addr !== 32'h40) begin
            nFailures++;
            $display("[TB] FAIL branch_align: got pc=%h expected 40", imem_addr);
        end
    endtask

    task automatic test_jump();
        doReset();
        applyStimulus(0, 0, 1, 32'h1000_0004, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(0, 0, 0, 0, 1, 26'h000_0010);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || imem_addr !== 32'h1000_0040) begin
            nFailures++;
            $display("[TB] FAIL jump_target: got pc=%h expected 10000040", imem_addr);
        end
        applyStimulus(0, 0, 1, 32'h80, 1, 26'h3FF_FFFF);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || imem_addr !== 32'h80) begin
            nFailures++;
            $display("[TB] FAIL branch_over_jump: got pc=%h expected 80", imem_addr);
        end
    endtask

    task automatic test_stall_redirect();
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(1, 0, 1, 32'h200, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || imem_addr !== 32'h200 || id_valid !== 1'b0 || fetch_count !== 32'd1) begin
            nFailures++;
            $display("[TB] FAIL stall_branch: got %h expected %h", act, expv);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(1, 1, 0, 0, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || imem_addr !== 32'h204 || id_valid !== 1'b0 || fetch_count !== 32'd2) begin
            nFailures++;
            $display("[TB] FAIL stall_flush: got %h expected %h", act, expv);
        end
    endtask

    task automatic test_wrap_reset();
        doReset();
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        void'(sbQ.pop_front());
        applyStimulus(0, 0, 0, 0, 0, 0);
        expv = sbQ.pop_front();
        act  = sampleDut();
        nChecks++;
        if (act !== expv || id_pc4 !== 32'h0 || imem_addr !== 32'h0 || id_instr !== 32'h4000_00FF) begin
            nFailures++;
            $display("[TB] FAIL pc_wrap: got %h expected %h", act, expv);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sbQ.pop_front());
        rst           = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        @(posedge clk);
        #1;
        rst = 1'b1;
        branch_taken = 1'b0;
        mdl = '0;
        act = sampleDut();
        nChecks++;
        if (act !== obs_t'(0)) begin
            nFailures++;
            $display("[TB] FAIL reset_during_redirect: got %h expected %h", act, obs_t'(0));
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 7) == 0, $urandom & 32'h0000_0FFF,
                          $urandom_range(0, 7) == 0, 26'($urandom));
            expv = sbQ.pop_front();
            act  = sampleDut();
            nChecks++;
            if (act !== expv) begin
                nFailures++;
                $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i, act, expv);
            end
        end
    endtask

    initial begin
        nChecks = 0;
        nFailures = 0;
        rst = 1'b0;
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_index = 0;
        mdl = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump();
        test_stall_redirect();
        test_wrap_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
